// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces sync, data-enable, active-pixel coordinates, line/frame start
// pulses and a completed-frame counter, advancing one pixel per CE.
// Optional cropped sub-window outputs are built when VGA_TIMING_WIN_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11,
  parameter int FRAME_W  = 8
`ifdef VGA_TIMING_WIN_EN
  ,
  parameter int WIN_X0   = 0,
  parameter int WIN_Y0   = 0,
  parameter int WIN_W    = H_ACTIVE,
  parameter int WIN_H    = V_ACTIVE
`endif
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  output logic               Hsync,
  output logic               Vsync,
  output logic               De,
  output logic [CW-1:0]      Pix_x,
  output logic [CW-1:0]      Pix_y,
  output logic               Line_start,
  output logic               Frame_start,
  output logic [FRAME_W-1:0] Frame_cnt
`ifdef VGA_TIMING_WIN_EN
  ,
  output logic               Win_de,
  output logic [CW-1:0]      Win_x,
  output logic [CW-1:0]      Win_y
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA_BEG  = H_SYNC + H_BP;
  localparam int HA_END  = H_SYNC + H_BP + H_ACTIVE;
  localparam int VA_BEG  = V_SYNC + V_BP;
  localparam int VA_END  = V_SYNC + V_BP + V_ACTIVE;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Counters must be able to reach the last pixel/line of the mode.
  generate
    if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_cw_too_small
      $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
    end
  endgenerate

  logic [CW-1:0]      h_q, h_d, v_q, v_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
  logic [CW-1:0]      pix_x_q, pix_y_q;

  logic [31:0]        h_w, v_w;
  logic               hs_act, vs_act, de_d;
  logic [CW-1:0]      pix_x_d, pix_y_d;

  // Decode of the current (pre-increment) position and next counter values.
  always_comb begin
    h_w         = 32'(h_q);
    v_w         = 32'(v_q);
    hs_act      = (h_w < H_SYNC);
    vs_act      = (v_w < V_SYNC);
    de_d        = (h_w >= HA_BEG) && (h_w < HA_END) && (v_w >= VA_BEG) && (v_w < VA_END);
    pix_x_d     = '0;
    pix_y_d     = '0;
    if (de_d) begin
      pix_x_d = CW'(h_w - HA_BEG);
      pix_y_d = CW'(v_w - VA_BEG);
    end
    h_d         = h_q + 1'b1;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d         = '0;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end else begin
        v_d = v_q + 1'b1;
      end
    end
  end

  // Raster counters and registered outputs; everything holds while CE is low
  // except the start pulses, which are forced low so they last one CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_cnt_q   <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (CE) begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_cnt_q   <= frame_cnt_d;
      hsync_q       <= hs_act ? HS_POL : ~HS_POL;
      vsync_q       <= vs_act ? VS_POL : ~VS_POL;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= (h_q == '0);
      frame_start_q <= (h_q == '0) && (v_q == '0);
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign De          = de_q;
  assign Pix_x       = pix_x_q;
  assign Pix_y       = pix_y_q;
  assign Line_start  = line_start_q;
  assign Frame_start = frame_start_q;
  assign Frame_cnt   = frame_cnt_q;

`ifdef VGA_TIMING_WIN_EN
  logic          win_de_q, win_de_d;
  logic [CW-1:0] win_x_q, win_x_d, win_y_q, win_y_d;
  logic [31:0]   px_w, py_w;

  // Window decode works on the same pre-increment pixel coordinates as De.
  always_comb begin
    px_w     = 32'(pix_x_d);
    py_w     = 32'(pix_y_d);
    win_de_d = de_d && (px_w >= WIN_X0) && (px_w < WIN_X0 + WIN_W) &&
               (py_w >= WIN_Y0) && (py_w < WIN_Y0 + WIN_H);
    win_x_d  = '0;
    win_y_d  = '0;
    if (win_de_d) begin
      win_x_d = CW'(px_w - WIN_X0);
      win_y_d = CW'(py_w - WIN_Y0);
    end
  end

  // Window outputs register alongside De.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_de_q <= 1'b0;
      win_x_q  <= '0;
      win_y_q  <= '0;
    end else if (CE) begin
      win_de_q <= win_de_d;
      win_x_q  <= win_x_d;
      win_y_q  <= win_y_d;
    end
  end

  assign Win_de = win_de_q;
  assign Win_x  = win_x_q;
  assign Win_y  = win_y_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen in a small 15x8 mode.
// Stimulus pushes expected outputs into a queue; a monitor pops and compares.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HSW + HB + HA + HF;   // 15
  localparam int VT = VSW + VB + VA + VF;   // 8
  localparam int FT = HT * VT;              // 120
  localparam int CW = 5;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic CE  = 1'b0;

  logic          a_hs, a_vs, a_de, a_ls, a_fs;
  logic [CW-1:0] a_px, a_py;
  logic [1:0]    a_fc;
  logic          b_hs, b_vs, b_de, b_ls, b_fs;
  logic [CW-1:0] b_px, b_py;
  logic [7:0]    b_fc;
`ifdef VGA_TIMING_WIN_EN
  logic          a_wde, b_wde;
  logic [CW-1:0] a_wx, a_wy, b_wx, b_wy;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .FRAME_W(2)
`ifdef VGA_TIMING_WIN_EN
    , .WIN_X0(2), .WIN_Y0(1), .WIN_W(3), .WIN_H(2)
`endif
  ) dut_a (
    .CLK(CLK), .RST(RST), .CE(CE),
    .Hsync(a_hs), .Vsync(a_vs), .De(a_de), .Pix_x(a_px), .Pix_y(a_py),
    .Line_start(a_ls), .Frame_start(a_fs), .Frame_cnt(a_fc)
`ifdef VGA_TIMING_WIN_EN
    , .Win_de(a_wde), .Win_x(a_wx), .Win_y(a_wy)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .FRAME_W(8)
  ) dut_b (
    .CLK(CLK), .RST(RST), .CE(CE),
    .Hsync(b_hs), .Vsync(b_vs), .De(b_de), .Pix_x(b_px), .Pix_y(b_py),
    .Line_start(b_ls), .Frame_start(b_fs), .Frame_cnt(b_fc)
`ifdef VGA_TIMING_WIN_EN
    , .Win_de(b_wde), .Win_x(b_wx), .Win_y(b_wy)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int hs_a, vs_a, hs_b, vs_b, de, px, py, ls, fs, fc;
    int wde, wx, wy;
    int tag;
  } exp_t;

  exp_t q[$];
  exp_t held;
  exp_t me;
  int   n;
  int   checks = 0;
  int   errors = 0;
  int   de_t = 0, hs_t = 0, vs_t = 0, hsb_t = 0, ls_t = 0, fs_t = 0, wde_t = 0;

  function automatic exp_t reset_exp();
    exp_t r;
    r.hs_a = 1; r.vs_a = 1; r.hs_b = 0; r.vs_b = 0;
    r.de = 0; r.px = 0; r.py = 0; r.ls = 0; r.fs = 0; r.fc = 0;
    r.wde = 0; r.wx = 0; r.wy = 0; r.tag = 0;
    return r;
  endfunction

  // Expected outputs after the CE edge that consumes pixel index idx since reset.
  function automatic exp_t decode(int idx);
    exp_t r;
    int h, v;
    r = reset_exp();
    h = idx % HT;
    v = (idx % FT) / HT;
    r.hs_a = (h < HSW) ? 0 : 1;
    r.hs_b = (h < HSW) ? 1 : 0;
    r.vs_a = (v < VSW) ? 0 : 1;
    r.vs_b = (v < VSW) ? 1 : 0;
    r.de   = (h >= HSW + HB && h < HSW + HB + HA && v >= VSW + VB && v < VSW + VB + VA) ? 1 : 0;
    if (r.de == 1) begin
      r.px = h - (HSW + HB);
      r.py = v - (VSW + VB);
    end
    r.ls = (h == 0) ? 1 : 0;
    r.fs = (h == 0 && v == 0) ? 1 : 0;
    r.fc = (idx + 1) / FT;
    if (r.de == 1 && r.px >= 2 && r.px < 5 && r.py >= 1 && r.py < 3) begin
      r.wde = 1;
      r.wx  = r.px - 2;
      r.wy  = r.py - 1;
    end
    return r;
  endfunction

  // Drive one CLK of stimulus and queue the outputs expected after its edge.
  task automatic step(input bit rst, input bit ce, input int tag);
    exp_t e;
    @(negedge CLK);
    RST = rst;
    CE  = ce;
    if (rst) begin
      e = reset_exp();
      n = 0;
      held = e;
    end else if (ce) begin
      e = decode(n);
      n = n + 1;
      held = e;
      held.ls = 0;
      held.fs = 0;
    end else begin
      e = held;
    end
    e.tag = tag;
    q.push_back(e);
  endtask

  // Raise reset between clock edges; the outputs must clear without a clock.
  task automatic async_reset();
    exp_t e;
    @(negedge CLK);
    #2;
    RST = 1'b1;
    CE  = 1'b1;
    n = 0;
    e = reset_exp();
    held = e;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: on a reset edge between clocks check reset values, otherwise
  // pop the expected output for this clock edge and compare.
  always @(posedge CLK or posedge RST) begin
    #1;
    if (CLK == 1'b0) begin
      chk("arst_hs_a", int'(a_hs), 1);
      chk("arst_vs_a", int'(a_vs), 1);
      chk("arst_hs_b", int'(b_hs), 0);
      chk("arst_vs_b", int'(b_vs), 0);
      chk("arst_de",   int'(a_de), 0);
      chk("arst_px",   int'(a_px), 0);
      chk("arst_py",   int'(a_py), 0);
      chk("arst_ls",   int'(a_ls), 0);
      chk("arst_fs",   int'(a_fs), 0);
      chk("arst_fc",   int'(a_fc), 0);
    end else if (q.size() > 0) begin
      me = q.pop_front();
      chk("hs_a", int'(a_hs), me.hs_a);
      chk("vs_a", int'(a_vs), me.vs_a);
      chk("hs_b", int'(b_hs), me.hs_b);
      chk("vs_b", int'(b_vs), me.vs_b);
      chk("de",   int'(a_de), me.de);
      chk("px",   int'(a_px), me.px);
      chk("py",   int'(a_py), me.py);
      chk("ls",   int'(a_ls), me.ls);
      chk("fs",   int'(a_fs), me.fs);
      chk("fc_a", int'(a_fc), me.fc % 4);
      chk("fc_b", int'(b_fc), me.fc % 256);
      chk("de_b", int'(b_de), me.de);
`ifdef VGA_TIMING_WIN_EN
      chk("wde",  int'(a_wde), me.wde);
      chk("wx",   int'(a_wx),  me.wx);
      chk("wy",   int'(a_wy),  me.wy);
`endif
      $display("cyc tag=%0d hs=%0d vs=%0d de=%0d x=%0d y=%0d ls=%0d fs=%0d fc=%0d",
               me.tag, a_hs, a_vs, a_de, a_px, a_py, a_ls, a_fs, a_fc);
      if (me.tag == 2) begin
        // Two continuous frames: 32 De, 3 Hsync per line, 30 Vsync per frame.
        chk("tally_de_2fr",    de_t,  64);
        chk("tally_hs_low",    hs_t,  48);
        chk("tally_vs_low",    vs_t,  60);
        chk("tally_hs_high_b", hsb_t, 48);
        chk("tally_ls",        ls_t,  16);
        chk("tally_fs",        fs_t,  2);
`ifdef VGA_TIMING_WIN_EN
        chk("tally_wde",       wde_t, 12);
`endif
      end
      if (me.tag == 4) begin
        // CE at half rate: levels held twice as long, pulses stay one CLK.
        chk("tally_de_half",   de_t,  128);
        chk("tally_hs_half",   hs_t,  96);
        chk("tally_ls_half",   ls_t,  16);
        chk("tally_fs_half",   fs_t,  2);
      end
      if (me.tag == 2 || me.tag == 4) begin
        de_t = 0; hs_t = 0; vs_t = 0; hsb_t = 0; ls_t = 0; fs_t = 0; wde_t = 0;
      end
      if (me.tag >= 1 && me.tag <= 3) begin
        de_t  = de_t  + int'(a_de);
        hs_t  = hs_t  + ((a_hs == 1'b0) ? 1 : 0);
        vs_t  = vs_t  + ((a_vs == 1'b0) ? 1 : 0);
        hsb_t = hsb_t + int'(b_hs);
        ls_t  = ls_t  + int'(a_ls);
        fs_t  = fs_t  + int'(a_fs);
`ifdef VGA_TIMING_WIN_EN
        wde_t = wde_t + int'(a_wde);
`endif
      end
    end
  end

  initial begin
    n = 0;
    held = reset_exp();
    #1 RST = 1'b1;
    repeat (3) step(1'b1, 1'b0, 0);
    // Two frames with CE held high.
    for (int i = 0; i < 2 * FT; i++) step(1'b0, 1'b1, 1);
    // CE toggling 1,0,1,0 for two frames.
    for (int i = 0; i < 4 * FT; i++) step(1'b0, (i % 2) == 0, (i == 0) ? 2 : 3);
    // Random CE.
    for (int i = 0; i < 700; i++) step(1'b0, ($urandom % 4) != 0, (i == 0) ? 4 : 0);
    // Reset mid-line while De is active (h=7, v=4), then replay from the start.
    repeat (2) step(1'b1, 1'b0, 0);
    for (int i = 0; i < 4 * HT + 8; i++) step(1'b0, 1'b1, 0);
    async_reset();
    repeat (2) step(1'b1, 1'b1, 0);
    // Five frames continuous: Frame_cnt of the 2-bit instance wraps.
    for (int i = 0; i < 5 * FT + 5; i++) step(1'b0, 1'b1, 0);
    repeat (4) @(posedge CLK);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
